// File: rtl/cordic_pkg.sv
// Shared constants and helpers for the shared CORDIC sine/cosine block.
package cordic_pkg;
  localparam int CORDIC_LAT = 31;
  localparam int CORDIC_DW  = 32;

  // ID field width; a single requester still needs a 1-bit field.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // atan(2^-i) with 2^31 == pi.
  function automatic logic [CORDIC_DW-1:0] atan_lut(input int i);
    case (i)
      0:  return 32'h20000000;  1:  return 32'h12E4051E;
      2:  return 32'h09FB385B;  3:  return 32'h051111D4;
      4:  return 32'h028B0D43;  5:  return 32'h0145D7E1;
      6:  return 32'h00A2F61E;  7:  return 32'h00517C55;
      8:  return 32'h0028BE53;  9:  return 32'h00145F2F;
      10: return 32'h000A2F98;  11: return 32'h000517CC;
      12: return 32'h00028BE6;  13: return 32'h000145F3;
      14: return 32'h0000A2FA;  15: return 32'h0000517D;
      16: return 32'h000028BE;  17: return 32'h0000145F;
      18: return 32'h00000A30;  19: return 32'h00000518;
      20: return 32'h0000028C;  21: return 32'h00000146;
      22: return 32'h000000A3;  23: return 32'h00000051;
      24: return 32'h00000029;  25: return 32'h00000014;
      26: return 32'h0000000A;  27: return 32'h00000005;
      28: return 32'h00000003;  29: return 32'h00000001;
      default: return '0;
    endcase
  endfunction
endpackage

// File: rtl/cordic_core.sv
// Fully pipelined rotation-mode CORDIC: one input stage plus 30 iterations.
module cordic_core import cordic_pkg::*; #(
  parameter int  DW = CORDIC_DW,
  parameter real K  = 0.6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [DW-1:0] angle,
  output logic [DW-1:0] cosine,
  output logic [DW-1:0] sine
);
  localparam int NI = CORDIC_LAT - 1;
  localparam logic signed [DW-1:0] KV  = DW'($rtoi(K * (2.0 ** (DW - 1))));
  localparam logic        [DW-1:0] QTR = {2'b01, {(DW-2){1'b0}}};

  logic signed [DW-1:0] x [0:NI];
  logic signed [DW-1:0] y [0:NI];
  logic signed [DW-1:0] z [0:NI];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= NI; i++) begin
        x[i] <= '0;
        y[i] <= '0;
        z[i] <= '0;
      end
    end else if (en) begin
      // Pre-rotate quadrants 1/2 by +-pi/2 so the residual stays inside convergence range.
      unique case (angle[DW-1 -: 2])
        2'b01:   begin x[0] <= '0; y[0] <= KV;  z[0] <= angle - QTR; end
        2'b10:   begin x[0] <= '0; y[0] <= -KV; z[0] <= angle + QTR; end
        default: begin x[0] <= KV; y[0] <= '0;  z[0] <= angle;       end
      endcase
      for (int i = 0; i < NI; i++) begin
        if (!z[i][DW-1]) begin
          x[i+1] <= x[i] - (y[i] >>> i);
          y[i+1] <= y[i] + (x[i] >>> i);
          z[i+1] <= z[i] - atan_lut(i);
        end else begin
          x[i+1] <= x[i] + (y[i] >>> i);
          y[i+1] <= y[i] - (x[i] >>> i);
          z[i+1] <= z[i] + atan_lut(i);
        end
      end
    end
  end

  assign cosine = x[NI];
  assign sine   = y[NI];
endmodule

// File: rtl/rr_arb.sv
// Combinational round-robin picker: first eligible index after ptr, wrapping.
module rr_arb #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   eligible,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] gid
);
  int idx;

  // Scan farthest-first so the nearest eligible index after ptr wins.
  always_comb begin
    grant = '0;
    gid   = '0;
    idx   = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(ptr) + k) % N;
      if (eligible[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        gid        = IDW'(idx);
      end
    end
  end
endmodule

// File: rtl/cordic_arbiter.sv
// Round-robin front end sharing one CORDIC core among N requesters, with per-requester in-flight caps.
module cordic_arbiter import cordic_pkg::*; #(
  parameter int  DW      = CORDIC_DW,
  parameter int  N       = 4,
  parameter int  MAX_OUT = 8,
  parameter real K       = 0.6,
  localparam int IDW     = id_w(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_valid,
  input  logic [N*DW-1:0] req_angle,
  output logic [N-1:0]    req_ready,
  output logic            res_valid,
  output logic [IDW-1:0]  res_id,
  output logic [DW-1:0]   res_cos,
  output logic [DW-1:0]   res_sin,
  output logic            busy
);
  localparam int CW  = $clog2(MAX_OUT + 1);
  localparam int LAT = CORDIC_LAT;

  typedef struct packed {
    logic           v;
    logic [IDW-1:0] id;
  } tag_t;

  logic [N-1:0][CW-1:0] cnt;
  logic [N-1:0]         eligible, grant;
  logic [IDW-1:0]       ptr, gid;
  logic                 accept;
  logic [DW-1:0]        core_angle;
  tag_t                 new_tag;
  tag_t [LAT-1:0]       tag_pipe;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < N; i++)
      eligible[i] = req_valid[i] && (cnt[i] != CW'(MAX_OUT));
  end

  rr_arb #(.N(N), .IDW(IDW)) u_rr (
    .eligible (eligible),
    .ptr      (ptr),
    .grant    (grant),
    .gid      (gid)
  );

  assign req_ready = grant & {N{rst_n}};
  assign accept    = |req_ready;
  assign new_tag   = '{v: accept, id: gid};

  always_comb begin
    core_angle = '0;
    for (int i = 0; i < N; i++)
      if (grant[i]) core_angle = req_angle[i*DW +: DW];
  end

  // Tag stage 0 loads on the same edge as the core input stage, so stage LAT-1 lines up with its output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= IDW'(N - 1);
      cnt      <= '0;
      tag_pipe <= '0;
    end else begin
      if (accept) ptr <= gid;
      tag_pipe <= {tag_pipe[LAT-2:0], new_tag};
      for (int i = 0; i < N; i++) begin
        if (req_ready[i] && !(res_valid && res_id == IDW'(i)))
          cnt[i] <= cnt[i] + CW'(1);
        else if (!req_ready[i] && res_valid && res_id == IDW'(i))
          cnt[i] <= cnt[i] - CW'(1);
      end
    end
  end

  assign res_valid = tag_pipe[LAT-1].v;
  assign res_id    = tag_pipe[LAT-1].id;

  always_comb begin
    busy = 1'b0;
    for (int s = 0; s < LAT; s++) busy = busy | tag_pipe[s].v;
  end

  cordic_core #(.DW(DW), .K(K)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (1'b1),
    .angle  (core_angle),
    .cosine (res_cos),
    .sine   (res_sin)
  );
endmodule

// File: tb/tb_cordic_arbiter.sv
// Bench for cordic_arbiter: queue-based reference of grants, caps and result timing, real-valued sin/cos.
module tb_cordic_arbiter;
  localparam int  N       = 4;
  localparam int  DW      = 32;
  localparam int  MAX_OUT = 8;
  localparam int  LAT     = 31;
  localparam real PI      = 3.14159265358979;
  localparam real AMP     = 0.6 * 1.6467602581210654 * 2147483648.0;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N*DW-1:0]   req_angle;
  logic [N-1:0]      req_ready;
  logic              res_valid;
  logic [1:0]        res_id;
  logic [DW-1:0]     res_cos, res_sin;
  logic              busy;

  cordic_arbiter #(.DW(DW), .N(N), .MAX_OUT(MAX_OUT), .K(0.6)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_angle(req_angle),
    .req_ready(req_ready), .res_valid(res_valid), .res_id(res_id),
    .res_cos(res_cos), .res_sin(res_sin), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int due; int id; logic [31:0] ang; } inflight_t;
  inflight_t q[$];
  int m_cnt[N];
  int m_ptr, edge_no;
  int checks = 0, errors = 0;
  logic [N-1:0] exp_ready;
  logic         exp_rv;
  int           exp_id;
  logic [31:0]  exp_ang;

  function automatic real cos_ref(input logic [31:0] a);
    return AMP * $cos($itor($signed(a)) * PI / 2147483648.0);
  endfunction
  function automatic real sin_ref(input logic [31:0] a);
    return AMP * $sin($itor($signed(a)) * PI / 2147483648.0);
  endfunction
  function automatic bit near(input logic [31:0] act, input real e);
    real d;
    d = $itor($signed(act)) - e;
    return (d < 4096.0) && (d > -4096.0);
  endfunction
  function automatic bit result_due();
    return (q.size() != 0) && (q[0].due == edge_no);
  endfunction

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_ptr = N - 1;
  endtask

  // Drive one cycle's inputs, derive the expected outcome, then wait for the sampling point.
  task automatic setup(input logic [N-1:0] v, input logic [N-1:0][31:0] a);
    int idx;
    req_valid = v;
    req_angle = a;
    exp_ready = '0;
    for (int k = 1; k <= N; k++) begin
      idx = (m_ptr + k) % N;
      if (v[idx] && m_cnt[idx] < MAX_OUT) begin
        exp_ready[idx] = 1'b1;
        break;
      end
    end
    exp_rv = result_due();
    exp_id = exp_rv ? q[0].id : 0;
    exp_ang = exp_rv ? q[0].ang : 32'h0;
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    if (exp_rv) begin
      m_cnt[q[0].id]--;
      void'(q.pop_front());
    end
    for (int i = 0; i < N; i++)
      if (exp_ready[i]) begin
        m_cnt[i]++;
        m_ptr = i;
        q.push_back('{due: edge_no + LAT, id: i, ang: req_angle[i*32 +: 32]});
      end
    edge_no++;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '0; req_angle = '0;
    #2; req_valid = '1; #1;
    checks += 4;
    if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    if (res_id !== 2'd0) begin errors++; $display("FAIL reset_res_id got %0d want 0", res_id); end
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b want 0000", req_ready); end
    @(negedge clk); req_valid = '0; rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
    edge_no = 0;
  endtask

  task automatic test_drain();
    logic [N-1:0][31:0] a;
    a = '0;
    for (int c = 0; c < 40 && q.size() != 0; c++) begin
      setup('0, a);
      checks += 2;
      if (req_ready !== exp_ready) begin errors++; $display("FAIL drain_grant e%0d got %b want %b", edge_no, req_ready, exp_ready); end
      if (res_valid !== exp_rv || busy !== (q.size() != 0)) begin errors++; $display("FAIL drain_valid e%0d got v%b b%b want v%b", edge_no, res_valid, busy, exp_rv); end
      if (exp_rv) begin
        checks++;
        if (res_id !== 2'(exp_id) || !near(res_cos, cos_ref(exp_ang)) || !near(res_sin, sin_ref(exp_ang))) begin
          errors++; $display("FAIL drain_data e%0d got id%0d %h %h want id%0d %0.0f %0.0f", edge_no, res_id, res_cos, res_sin, exp_id, cos_ref(exp_ang), sin_ref(exp_ang)); end
      end
      advance();
    end
  endtask

  task automatic test_single();
    logic [N-1:0][31:0] a;
    a = '0;
    for (int c = 0; c < 33; c++) begin
      setup(c == 0 ? 4'b0001 : 4'b0000, a);
      checks += 2;
      if (req_ready !== exp_ready) begin errors++; $display("FAIL single_grant e%0d got %b want %b", edge_no, req_ready, exp_ready); end
      if (res_valid !== exp_rv || busy !== (q.size() != 0)) begin errors++; $display("FAIL single_valid e%0d got v%b b%b want v%b", edge_no, res_valid, busy, exp_rv); end
      if (exp_rv) begin
        checks++;
        if (res_id !== 2'(exp_id) || !near(res_cos, cos_ref(exp_ang)) || !near(res_sin, sin_ref(exp_ang))) begin
          errors++; $display("FAIL single_data e%0d got id%0d %h %h want id%0d %0.0f %0.0f", edge_no, res_id, res_cos, res_sin, exp_id, cos_ref(exp_ang), sin_ref(exp_ang)); end
      end
      advance();
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0][31:0] a;
    for (int i = 0; i < N; i++) a[i] = 32'h20000000;
    for (int c = 0; c < 45; c++) begin
      setup('1, a);
      checks += 2;
      if (req_ready !== exp_ready) begin errors++; $display("FAIL rr_grant e%0d got %b want %b", edge_no, req_ready, exp_ready); end
      if (res_valid !== exp_rv || busy !== (q.size() != 0)) begin errors++; $display("FAIL rr_valid e%0d got v%b b%b want v%b", edge_no, res_valid, busy, exp_rv); end
      if (exp_rv) begin
        checks++;
        if (res_id !== 2'(exp_id) || !near(res_cos, cos_ref(exp_ang)) || !near(res_sin, sin_ref(exp_ang))) begin
          errors++; $display("FAIL rr_data e%0d got id%0d %h %h want id%0d %0.0f %0.0f", edge_no, res_id, res_cos, res_sin, exp_id, cos_ref(exp_ang), sin_ref(exp_ang)); end
      end
      advance();
    end
    test_drain();
  endtask

  task automatic test_max_out();
    logic [N-1:0][31:0] a;
    int acc [2];
    acc[0] = 0; acc[1] = 0;
    for (int c = 0; c < 64; c++) begin
      for (int i = 0; i < N; i++) a[i] = $urandom();
      setup(4'b0100, a);
      if (req_ready[2] === 1'b1) acc[c / 32]++;
      checks += 2;
      if (req_ready !== exp_ready) begin errors++; $display("FAIL maxout_grant e%0d got %b want %b", edge_no, req_ready, exp_ready); end
      if (res_valid !== exp_rv || busy !== (q.size() != 0)) begin errors++; $display("FAIL maxout_valid e%0d got v%b b%b want v%b", edge_no, res_valid, busy, exp_rv); end
      if (exp_rv) begin
        checks++;
        if (res_id !== 2'(exp_id) || !near(res_cos, cos_ref(exp_ang)) || !near(res_sin, sin_ref(exp_ang))) begin
          errors++; $display("FAIL maxout_data e%0d got id%0d %h %h want id%0d %0.0f %0.0f", edge_no, res_id, res_cos, res_sin, exp_id, cos_ref(exp_ang), sin_ref(exp_ang)); end
      end
      advance();
    end
    // Accept at cycle c frees its slot for cycle c+32: eight accepts per 32-cycle window.
    for (int w = 0; w < 2; w++) begin
      checks++;
      if (acc[w] != MAX_OUT) begin errors++; $display("FAIL maxout_window%0d accepts got %0d want %0d", w, acc[w], MAX_OUT); end
    end
    test_drain();
  endtask

  task automatic test_quadrant();
    logic [N-1:0][31:0] a;
    logic [31:0] tbl [6];
    tbl = '{32'h60000000, 32'hA0000000, 32'h80000000, 32'h40000000, 32'hC0000000, 32'h3FFFFFFF};
    for (int c = 0; c < 6 + LAT; c++) begin
      a = '0;
      a[1] = (c < 6) ? tbl[c] : 32'h0;
      setup(c < 6 ? 4'b0010 : 4'b0000, a);
      checks += 2;
      if (req_ready !== exp_ready) begin errors++; $display("FAIL quad_grant e%0d got %b want %b", edge_no, req_ready, exp_ready); end
      if (res_valid !== exp_rv || busy !== (q.size() != 0)) begin errors++; $display("FAIL quad_valid e%0d got v%b b%b want v%b", edge_no, res_valid, busy, exp_rv); end
      if (exp_rv) begin
        checks++;
        if (res_id !== 2'(exp_id) || !near(res_cos, cos_ref(exp_ang)) || !near(res_sin, sin_ref(exp_ang))) begin
          errors++; $display("FAIL quad_data e%0d ang %h got id%0d %h %h want id%0d %0.0f %0.0f", edge_no, exp_ang, res_id, res_cos, res_sin, exp_id, cos_ref(exp_ang), sin_ref(exp_ang)); end
      end
      advance();
    end
    test_drain();
  endtask

  task automatic test_random();
    logic [N-1:0][31:0] a;
    logic [N-1:0] v;
    for (int c = 0; c < 250; c++) begin
      for (int i = 0; i < N; i++) a[i] = $urandom();
      v = N'($urandom_range(0, 15));
      setup(v, a);
      checks += 2;
      if (req_ready !== exp_ready) begin errors++; $display("FAIL rand_grant e%0d got %b want %b", edge_no, req_ready, exp_ready); end
      if (res_valid !== exp_rv || busy !== (q.size() != 0)) begin errors++; $display("FAIL rand_valid e%0d got v%b b%b want v%b", edge_no, res_valid, busy, exp_rv); end
      if (exp_rv) begin
        checks++;
        if (res_id !== 2'(exp_id) || !near(res_cos, cos_ref(exp_ang)) || !near(res_sin, sin_ref(exp_ang))) begin
          errors++; $display("FAIL rand_data e%0d ang %h got id%0d %h %h want id%0d %0.0f %0.0f", edge_no, exp_ang, res_id, res_cos, res_sin, exp_id, cos_ref(exp_ang), sin_ref(exp_ang)); end
      end
      advance();
    end
    test_drain();
  endtask

  // Seven in flight on requester 0, then request exactly when the first one returns.
  task automatic test_same_cycle();
    logic [N-1:0][31:0] a;
    logic [N-1:0] v;
    for (int c = 0; c < 45; c++) begin
      for (int i = 0; i < N; i++) a[i] = $urandom();
      v = (c < MAX_OUT - 1 || result_due() || c > 40) ? 4'b0001 : 4'b0000;
      if (c > 42) v = '0;
      setup(v, a);
      if (exp_rv && q.size() == MAX_OUT - 1) begin
        checks++;
        if (req_ready[0] !== 1'b1 || res_valid !== 1'b1 || res_id !== 2'd0) begin
          errors++; $display("FAIL same_cycle_edge e%0d got ready%b v%b id%0d want 1 1 0", edge_no, req_ready[0], res_valid, res_id); end
      end
      checks += 2;
      if (req_ready !== exp_ready) begin errors++; $display("FAIL same_grant e%0d got %b want %b", edge_no, req_ready, exp_ready); end
      if (res_valid !== exp_rv || busy !== (q.size() != 0)) begin errors++; $display("FAIL same_valid e%0d got v%b b%b want v%b", edge_no, res_valid, busy, exp_rv); end
      if (exp_rv) begin
        checks++;
        if (res_id !== 2'(exp_id) || !near(res_cos, cos_ref(exp_ang)) || !near(res_sin, sin_ref(exp_ang))) begin
          errors++; $display("FAIL same_data e%0d got id%0d %h %h want id%0d %0.0f %0.0f", edge_no, res_id, res_cos, res_sin, exp_id, cos_ref(exp_ang), sin_ref(exp_ang)); end
      end
      advance();
    end
    test_drain();
  endtask

  task automatic test_reset_mid();
    logic [N-1:0][31:0] a;
    for (int c = 0; c < 45 && !(c >= 10 && result_due()); c++) begin
      for (int i = 0; i < N; i++) a[i] = $urandom();
      setup(c < 10 ? 4'b1111 : 4'b0000, a);
      checks += 2;
      if (req_ready !== exp_ready) begin errors++; $display("FAIL rstmid_grant e%0d got %b want %b", edge_no, req_ready, exp_ready); end
      if (res_valid !== exp_rv || busy !== (q.size() != 0)) begin errors++; $display("FAIL rstmid_valid e%0d got v%b b%b want v%b", edge_no, res_valid, busy, exp_rv); end
      advance();
    end
    req_valid = '0;
    #3;
    checks += 3;
    if (q.size() != 10) begin errors++; $display("FAIL rstmid_inflight got %0d want 10", q.size()); end
    if (res_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL rstmid_before got v%b b%b want 1 1", res_valid, busy); end
    rst_n = 1'b0; #1;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_async got v%b b%b want 0 0", res_valid, busy); end
    req_valid = '1; #1;
    checks++;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL rstmid_ready got %b want 0000", req_ready); end
    @(negedge clk); req_valid = '0; rst_n = 1'b1;
    @(posedge clk); #1;
    edge_no++;
    model_reset();
    a = '0;
    setup('1, a);
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL rstmid_first_grant got %b want 0001", req_ready); end
    advance();
    test_drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_max_out();
    test_quadrant();
    test_same_cycle();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at edge %0d", edge_no);
    $fatal(1, "timeout");
  end
endmodule
